// File: rtl/serial_complementer.sv
// Digit-serial two's-complement unit: pass, ones' complement, negate, absolute value.
// Consumes DIGIT bits per cycle, LSB first, and signals overflow for the most negative operand.
// Optional feature macro: COMP_SATURATE_EN (overflow cases return the most positive value).
module serial_complementer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] dataIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] dataOut,
    output logic             overflow
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    // Reject geometries the digit-serial datapath cannot handle
    if ((WIDTH < 2) || (DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("serial_complementer: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef COMP_SATURATE_EN
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               inv_q, inv_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               overflow_q, overflow_d;

    logic [DIGIT-1:0]   digit_c;
    logic               carry_out_c;
    logic [WIDTH-1:0]   res_next_c;
    logic               msb_c;

    // Datapath for one digit and next-state / output decisions
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        inv_d       = inv_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        overflow_d  = overflow_q;

        msb_c = dataIn[WIDTH-1];
        {carry_out_c, digit_c} = {1'b0, op_q[DIGIT-1:0] ^ {DIGIT{inv_q}}} + (DIGIT+1)'(carry_q);
        // New digit enters from the MSB side; after N digits the result is aligned
        res_next_c = (res_q >> DIGIT) | (WIDTH'(digit_c) << (WIDTH - DIGIT));

        case (state_q)
            IDLE: begin
                if (inValid) begin
                    op_d       = dataIn;
                    res_d      = '0;
                    cnt_d      = '0;
                    inv_d      = (mode == 2'b11) ? msb_c : (mode[0] | mode[1]);
                    carry_d    = (mode == 2'b10) || ((mode == 2'b11) && msb_c);
                    ovf_d      = mode[1] && (dataIn == MOST_NEG);
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                op_d    = op_q >> DIGIT;
                res_d   = res_next_c;
                carry_d = carry_out_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
`ifdef COMP_SATURATE_EN
                    data_out_d = ovf_q ? MOST_POS : res_next_c;
`else
                    data_out_d = res_next_c;
`endif
                    overflow_d  = ovf_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (outReady) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            inv_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            inv_q       <= inv_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign inReady  = in_ready_q;
    assign outValid = out_valid_q;
    assign dataOut  = data_out_q;
    assign overflow = overflow_q;

endmodule
